// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS data-memory store path: access sizes and
// store-unit FSM states.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/store_unit_if.sv
// Store request/response from the MEM stage and the write port to data memory.
// The master modport is the store unit itself; slave is the surrounding system.
interface store_unit_if #(
  parameter int ADDR_W = 32
);

  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_done;
  logic              st_err;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;

  modport master (
    input  st_valid, st_size, st_addr, st_data, mem_ack,
    output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output st_valid, st_size, st_addr, st_data, mem_ack,
    input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/store_lane_steer.sv
// Narrows a 32-bit register value into little-endian byte lanes and flags
// stores that are misaligned or use the reserved size.
module store_lane_steer
  import mips_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // NOTE: every output gets a default before the case so no path through the
  // block leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    be       = 4'b0000;
    wdata    = data;
    misalign = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{data[15:0]}};
        misalign = addr[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = |addr;
      end
      SZ_RSVD: begin
        misalign = 1'b1;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store path of the MIPS MEM stage: accepts SB/SH/SW, registers a lane-steered
// word write and holds it on the memory port until acknowledged.
module store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  store_unit_if.master  bus
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misalign;

  store_lane_steer u_steer (
    .size     (size_t'(bus.st_size)),
    .addr     (bus.st_addr[1:0]),
    .data     (bus.st_data),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .misalign (misalign)
  );

  // Acceptance depends only on the registered state, never on mem_* inputs.
  assign accept = bus.st_valid && (state == ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.st_ready = 1'b0;
    bus.mem_req  = 1'b0;
    bus.st_done  = 1'b0;
    bus.st_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.st_ready = 1'b1;
        if (accept) state_next = misalign ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.st_done = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_ERR: begin
        bus.st_done = 1'b1;
        bus.st_err  = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: the write-port registers are cleared by reset because their reset
  // values are architecturally visible; they load only at acceptance so they
  // stay frozen for the whole request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else if (accept) begin
      bus.mem_addr  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
      bus.mem_wdata <= lane_wdata;
      bus.mem_be    <= lane_be;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: a transaction-level model checked every
// cycle, plus directed stores with hand-computed literal expectations.
module tb_store_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_delay = 0;
  int   ack_wait = 0;

  store_unit_if #(.ADDR_W(32)) bus ();

  store_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what an accepted store must produce on the memory port.
  function automatic void expect_store(input logic [1:0] sz, input logic [31:0] a,
                                       input logic [31:0] d, output bit ok,
                                       output logic [3:0] be, output logic [31:0] wd);
    int k;
    k  = int'(a[1:0]);
    ok = 1'b0;
    be = 4'b0000;
    wd = d;
    case (sz)
      2'b00: begin ok = 1'b1; be = 4'(1 << k); wd = {24'b0, d[7:0]} * 32'h0101_0101; end
      2'b01: begin ok = (k % 2 == 0); be = 4'(3 << k); wd = {16'b0, d[15:0]} * 32'h0001_0001; end
      2'b10: begin ok = (k == 0); be = 4'hF; wd = d; end
      default: ok = 1'b0;
    endcase
  endfunction

  // Model: a legal store occupies the memory port until acked, then reports
  // done the next cycle; an illegal one reports done+err the cycle after accept.
  bit          m_pend, m_done, m_err, m_ok, n_done, n_err;
  logic [31:0] m_addr, m_wdata, t_wdata;
  logic [3:0]  m_be, t_be;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      n_done = 1'b0;
      n_err  = 1'b0;
      if (m_pend) begin
        if (bus.mem_ack) begin
          m_pend = 1'b0;
          n_done = 1'b1;
        end
      end else if (!m_done && bus.st_valid) begin
        expect_store(bus.st_size, bus.st_addr, bus.st_data, m_ok, t_be, t_wdata);
        if (m_ok) begin
          m_pend  = 1'b1;
          m_addr  = {bus.st_addr[31:2], 2'b00};
          m_be    = t_be;
          m_wdata = t_wdata;
        end else begin
          n_done = 1'b1;
          n_err  = 1'b1;
        end
      end
      m_done = n_done;
      m_err  = n_err;
    end
  end

  always @(negedge clk) begin
    check("st_ready", bus.st_ready, !m_pend && !m_done);
    check("mem_req",  bus.mem_req,  m_pend);
    check("st_done",  bus.st_done,  m_done);
    check("st_err",   bus.st_err,   m_err);
    if (m_pend) begin
      check("mem_addr",  bus.mem_addr,  m_addr);
      check("mem_be",    bus.mem_be,    m_be);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
  end

  // Memory responder: acks after ack_delay wait cycles of mem_req.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (ack_wait >= ack_delay) begin
          bus.mem_ack = 1'b1;
          ack_wait    = 0;
        end else begin
          bus.mem_ack = 1'b0;
          ack_wait++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        ack_wait    = 0;
      end
    end
  end

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       input bit keep, output int acc);
    int guard;
    guard        = 0;
    bus.st_valid = 1'b1;
    bus.st_size  = sz;
    bus.st_addr  = a;
    bus.st_data  = d;
    @(negedge clk);
    while (!bus.st_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.st_ready) check("accept_timeout", 32'd0, 32'd1);
    acc = int'($time / 10);
    @(posedge clk);
    #1;
    if (!keep) bus.st_valid = 1'b0;
  endtask

  task automatic wait_done(output int dn, output logic err, output int reqs,
                           output logic [31:0] a, output logic [31:0] w, output logic [3:0] b);
    int guard;
    bit seen;
    guard = 0; seen = 1'b0; reqs = 0; dn = -1; err = 1'b0;
    a = '0; w = '0; b = '0;
    while (!seen && guard < 40) begin
      @(negedge clk);
      guard++;
      if (bus.mem_req) begin
        if (reqs == 0) begin
          a = bus.mem_addr;
          w = bus.mem_wdata;
          b = bus.mem_be;
        end
        reqs++;
      end
      if (bus.st_done) begin
        seen = 1'b1;
        dn   = int'($time / 10);
        err  = bus.st_err;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  int          acc, acc2, dn, reqs;
  logic        err;
  logic [31:0] a, w;
  logic [3:0]  b;
  logic [3:0]  byte_be [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    bus.st_valid = 1'b0;
    bus.st_size  = SZ_BYTE;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_addr",  bus.mem_addr,  32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be",    bus.mem_be,    32'h0);
    check("rst_ready",     bus.st_ready,  32'h1);
    @(posedge clk);
    #2 rst = 1'b0;

    // SB at lane 3
    store(SZ_BYTE, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sb_latency", dn - acc, 32'd2);
    check("sb_err",     err,      32'd0);
    check("sb_addr",    a,        32'h0000_1000);
    check("sb_be",      b,        32'h8);
    check("sb_wdata",   w,        32'hDDDD_DDDD);
    check("sb_reqs",    reqs,     32'd1);

    // SH at offset 2 with three wait cycles
    ack_delay = 3;
    store(SZ_HALF, 32'h0000_2002, 32'h1234_5678, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sh_be",      b,        32'hC);
    check("sh_wdata",   w,        32'h5678_5678);
    check("sh_reqs",    reqs,     32'd4);
    check("sh_latency", dn - acc, 32'd5);
    ack_delay = 0;

    // SW, then misaligned SH, reserved size and misaligned SW
    store(SZ_WORD, 32'h0000_3000, 32'hCAFE_F00D, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sw_be",    b, 32'hF);
    check("sw_wdata", w, 32'hCAFE_F00D);
    store(SZ_HALF, 32'h0000_3001, 32'h0000_BEEF, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sh_mis_latency", dn - acc, 32'd1);
    check("sh_mis_err",     err,      32'd1);
    check("sh_mis_reqs",    reqs,     32'd0);
    store(SZ_RSVD, 32'h0000_3004, 32'h1111_2222, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("rsvd_err",  err,  32'd1);
    check("rsvd_reqs", reqs, 32'd0);
    store(SZ_WORD, 32'h0000_3002, 32'h3333_4444, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sw_mis_err", err, 32'd1);

    // Every byte lane and both halfword lanes
    for (int k = 0; k < 4; k++) begin
      store(SZ_BYTE, 32'h0000_6000 + 32'(k), 32'h0000_00A0 + 32'(k), 1'b0, acc);
      wait_done(dn, err, reqs, a, w, b);
      check("lane_be", b, byte_be[k]);
    end
    store(SZ_HALF, 32'h0000_6000, 32'hFFFF_9876, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("sh0_be",    b, 32'h3);
    check("sh0_wdata", w, 32'h9876_9876);

    // Back-to-back: second store presented while the first is in REQ
    ack_delay = 1;
    store(SZ_WORD, 32'h0000_4000, 32'h1111_1111, 1'b1, acc);
    store(SZ_WORD, 32'h0000_4004, 32'h2222_2222, 1'b0, acc2);
    check("b2b_spacing", acc2 - acc, 32'd4);
    wait_done(dn, err, reqs, a, w, b);
    check("b2b_addr",  a, 32'h0000_4004);
    check("b2b_wdata", w, 32'h2222_2222);
    ack_delay = 0;

    // Reset while waiting for an ack that never comes
    ack_delay = 1000;
    store(SZ_BYTE, 32'h0000_5000, 32'h0000_0099, 1'b0, acc);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", bus.mem_req,   32'd0);
    check("rst_ready_mid", bus.st_ready, 32'd1);
    check("rst_done_mid", bus.st_done,   32'd0);
    check("rst_be_mid",   bus.mem_be,    32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    ack_delay = 0;
    store(SZ_BYTE, 32'h0000_5001, 32'h0000_00EE, 1'b0, acc);
    wait_done(dn, err, reqs, a, w, b);
    check("post_rst_be",      b,        32'h2);
    check("post_rst_wdata",   w,        32'hEEEE_EEEE);
    check("post_rst_latency", dn - acc, 32'd2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_unit.md
# store_unit

Data-memory store path for the MIPS core: accepts a store (SB/SH/SW) from the MEM stage, narrows and lane-steers the 32-bit register value into a word-aligned memory write with byte enables, and runs a request/acknowledge handshake with data memory. It is the write-direction counterpart of the immediate and load-data extension logic: extension widens narrow values into 32 bits, and this block narrows 32-bit values into byte or halfword memory writes. It also flags misaligned stores instead of issuing them.

## Interface
- ADDR_W, 32, byte-address width of `st_addr` and `mem_addr`.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the MEM stage.
- st_ready  out  1  unit can accept a store; high only in IDLE.
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  register value; the low byte, low half or full word is used.
- st_done  out  1  one-cycle pulse; the accepted store has completed or was rejected.
- st_err  out  1  one-cycle pulse together with `st_done`; the store was misaligned or used a reserved size.
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  word-aligned address, {st_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-steered write data.
- mem_be  out  4  byte enables; bit k covers mem_wdata[8k+7:8k].
- mem_ack  in  1  memory accepted the write; ignored while `mem_req` is 0.

## Operation
- Byte order is little-endian. Byte offset k = st_addr[1:0] selects lane k.
- Byte store: mem_be = 1<<k. mem_wdata = {4{st_data[7:0]}}.
- Halfword store: legal only if st_addr[0]=0. mem_be = 0011 for offset 0, 1100 for offset 2. mem_wdata = {2{st_data[15:0]}}.
- Word store: legal only if st_addr[1:0]=00. mem_be = 1111. mem_wdata = st_data.
- Error stores: a misaligned address, or st_size=11, is still accepted. It issues no `mem_req` and produces `st_done` and `st_err` together.
- Handshake: a store is accepted on a cycle where st_valid && st_ready. `mem_addr`, `mem_wdata` and `mem_be` are registered at acceptance.
- FSM states:
  - IDLE: `st_ready`=1. On a legal accept, go to REQ. On an error accept, go to ERR. Otherwise stay in IDLE.
  - REQ: `mem_req`=1, with address, data and byte enables held stable. If `mem_ack`=1, go to DONE; otherwise stay in REQ indefinitely.
  - DONE: `st_done`=1 for one cycle, then go to IDLE.
  - ERR: `st_done`=1 and `st_err`=1 for one cycle, then go to IDLE.
- `st_valid` outside IDLE is ignored, and the MEM stage must keep it asserted (stall). `st_ready` is a combinational decode of the state.
- Reset values: state IDLE, `st_ready`=1, `st_done`=0, `st_err`=0, `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0.
- Reset mid-transaction: `mem_req` drops asynchronously and the store is abandoned, with no `st_done`. Memory must treat a request withdrawn by reset as not issued.

## Timing
- Legal store, memory acknowledging immediately: accept at cycle 0, `mem_req` in cycle 1, `mem_ack` in cycle 1, `st_done` in cycle 2, next accept possible in cycle 3. Throughput is one store per 3 cycles.
- Each wait cycle on `mem_ack` adds one cycle to that latency.
- Error store: accept at cycle 0, `st_done` and `st_err` in cycle 1, IDLE in cycle 2.
- `mem_req` never rises in the cycle of acceptance, so there is no combinational path from `st_*` to `mem_*`.

## Structure
- Shared package `mips_pkg` holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state encoding for IDLE, REQ, DONE, ERR.
- One combinational sub-module, `store_lane_steer`:
  - inputs: size, addr[1:0], data;
  - outputs: be, wdata, misalign.
- The top level holds the FSM and the output registers.

## Test plan
- SB at 0x1003, data 0xAABBCCDD → mem_addr 0x1000, mem_be 1000, mem_wdata 0xDDDDDDDD, `st_done` 2 cycles after accept, `st_err`=0.
- SH at 0x2002, data 0x12345678; `mem_ack` delayed 3 cycles → mem_be 1100, mem_wdata 0x56785678, all `mem_*` stable for 4 cycles, `st_done` 1 cycle after ack.
- SW at 0x3000, data 0xCAFEF00D → mem_be 1111, mem_wdata 0xCAFEF00D. Then SH at 0x3001 → no `mem_req`, `st_done` and `st_err` in the cycle after accept.
- st_size=11 at an aligned address → same response as a misaligned store: `st_err` pulse, no `mem_req`.
- Back-to-back `st_valid` with a new value presented while in REQ → the second store is not accepted until IDLE, and the first store's `mem_wdata` is unchanged.
- Assert `rst` while in REQ before `mem_ack` → `mem_req`=0 immediately, no `st_done`, `st_ready`=1, and a new SB is accepted normally after reset releases.
